// File: rtl/cache_stub_mem.sv
// Unified word RAM behind icache/dcache ports with one-line tags and a miss-latency stall model.
// Optional build macro STALL_STATS_EN enables saturating per-port miss counters.
module cache_stub_mem #(
  parameter int ADDR_WIDTH   = 12,
  parameter int LINE_WORDS   = 4,
  parameter int MISS_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] icache_addr,
  input  logic        icache_re,
  input  logic [3:0]  icache_we,
  input  logic [31:0] icache_din,
  output logic [31:0] instruction,
  input  logic [31:0] dcache_addr,
  input  logic        dcache_re,
  input  logic [3:0]  dcache_we,
  input  logic [31:0] dcache_din,
  output logic [31:0] dcache_dout,
  output logic        stall,
  output logic [31:0] miss_count_i,
  output logic [31:0] miss_count_d
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int TAG_W = ADDR_WIDTH - OFF_W;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = (MISS_LATENCY > 1) ? $clog2(MISS_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MISS_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL_I = 2'd1,
    S_FILL_D = 2'd2
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [TAG_W-1:0]   tag_i_q, tag_d_q;
  logic               tag_vld_i_q, tag_vld_d_q;
  logic [31:0]        instruction_q, dcache_dout_q;
  logic [31:0]        mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] i_idx, d_idx;
  logic [TAG_W-1:0]      i_tag, d_tag;
  logic                  i_act, d_act, i_miss, d_miss, acc;

  assign i_idx = icache_addr[ADDR_WIDTH+1:2];
  assign d_idx = dcache_addr[ADDR_WIDTH+1:2];
  assign i_tag = icache_addr[ADDR_WIDTH+1:2+OFF_W];
  assign d_tag = dcache_addr[ADDR_WIDTH+1:2+OFF_W];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{icache_addr[31:ADDR_WIDTH+2], icache_addr[1:0],
                              dcache_addr[31:ADDR_WIDTH+2], dcache_addr[1:0]};

  assign i_act  = icache_re || (icache_we != 4'b0000);
  assign d_act  = dcache_re || (dcache_we != 4'b0000);
  assign i_miss = i_act && (!tag_vld_i_q || (tag_i_q != i_tag));
  assign d_miss = d_act && (!tag_vld_d_q || (tag_d_q != d_tag));

  assign stall = (state_q != S_IDLE) || i_miss || d_miss;
  assign acc   = !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tag_i_q     <= '0;
      tag_d_q     <= '0;
      tag_vld_i_q <= 1'b0;
      tag_vld_d_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // I-side fill always goes first; a pending D miss follows it directly.
          if (i_miss) begin
            state_q <= S_FILL_I;
            cnt_q   <= CNT_LOAD;
          end else if (d_miss) begin
            state_q <= S_FILL_D;
            cnt_q   <= CNT_LOAD;
          end
        end
        S_FILL_I: begin
          if (cnt_q == '0) begin
            tag_i_q     <= i_tag;
            tag_vld_i_q <= 1'b1;
            if (d_miss) begin
              state_q <= S_FILL_D;
              cnt_q   <= CNT_LOAD;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_FILL_D: begin
          if (cnt_q == '0) begin
            tag_d_q     <= d_tag;
            tag_vld_d_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // RAM is never cleared; I-port lanes are written last so they win same-lane conflicts.
  always_ff @(posedge clk) begin
    if (!rst && acc) begin
      for (int k = 0; k < 4; k++) begin
        if (dcache_we[k]) mem_q[d_idx][8*k +: 8] <= dcache_din[8*k +: 8];
      end
      for (int k = 0; k < 4; k++) begin
        if (icache_we[k]) mem_q[i_idx][8*k +: 8] <= icache_din[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instruction_q <= '0;
      dcache_dout_q <= '0;
    end else begin
      if (acc && icache_re) instruction_q <= mem_q[i_idx];
      if (acc && dcache_re) dcache_dout_q <= mem_q[d_idx];
    end
  end

  assign instruction = instruction_q;
  assign dcache_dout = dcache_dout_q;

`ifdef STALL_STATS_EN
  logic [31:0] miss_cnt_i_q, miss_cnt_d_q;
  logic        inc_i, inc_d;

  assign inc_i = (state_q == S_IDLE) && i_miss;
  assign inc_d = ((state_q == S_IDLE) && !i_miss && d_miss) ||
                 ((state_q == S_FILL_I) && (cnt_q == '0) && d_miss);

  always_ff @(posedge clk) begin
    if (rst) begin
      miss_cnt_i_q <= '0;
      miss_cnt_d_q <= '0;
    end else begin
      if (inc_i && (miss_cnt_i_q != 32'hFFFF_FFFF)) miss_cnt_i_q <= miss_cnt_i_q + 32'd1;
      if (inc_d && (miss_cnt_d_q != 32'hFFFF_FFFF)) miss_cnt_d_q <= miss_cnt_d_q + 32'd1;
    end
  end

  assign miss_count_i = miss_cnt_i_q;
  assign miss_count_d = miss_cnt_d_q;
`else
  assign miss_count_i = '0;
  assign miss_count_d = '0;
`endif

endmodule

// File: tb/tb_cache_stub_mem.sv
// Directed bench for cache_stub_mem with default parameters (ADDR_WIDTH=12, LINE_WORDS=4, MISS_LATENCY=4).
module tb_cache_stub_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] icache_addr, icache_din, dcache_addr, dcache_din;
  logic        icache_re, dcache_re;
  logic [3:0]  icache_we, dcache_we;
  logic [31:0] instruction, dcache_dout, miss_count_i, miss_count_d;
  logic        stall;

  int n_vec = 0;
  int n_err = 0;
  int st;

`ifdef STALL_STATS_EN
  localparam logic [31:0] EXP_DUAL_CNT = 32'd1;
`else
  localparam logic [31:0] EXP_DUAL_CNT = 32'd0;
`endif

  cache_stub_mem dut (
    .clk          (clk),
    .rst          (rst),
    .icache_addr  (icache_addr),
    .icache_re    (icache_re),
    .icache_we    (icache_we),
    .icache_din   (icache_din),
    .instruction  (instruction),
    .dcache_addr  (dcache_addr),
    .dcache_re    (dcache_re),
    .dcache_we    (dcache_we),
    .dcache_din   (dcache_din),
    .dcache_dout  (dcache_dout),
    .stall        (stall),
    .miss_count_i (miss_count_i),
    .miss_count_d (miss_count_d)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    icache_addr = '0; icache_re = 1'b0; icache_we = '0; icache_din = '0;
    dcache_addr = '0; dcache_re = 1'b0; dcache_we = '0; dcache_din = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Holds the request until stall drops, counts stalled cycles, then lets the access take the edge.
  task automatic access(input logic [31:0] ia, input logic ire, input logic [3:0] iwe, input logic [31:0] idin,
                        input logic [31:0] da, input logic dre, input logic [3:0] dwe, input logic [31:0] ddin,
                        output int stalls);
    icache_addr = ia; icache_re = ire; icache_we = iwe; icache_din = idin;
    dcache_addr = da; dcache_re = dre; dcache_we = dwe; dcache_din = ddin;
    stalls = 0;
    #1;
    while (stall === 1'b1 && stalls < 40) begin
      stalls++;
      @(posedge clk);
      #1;
    end
    if (stalls >= 40) begin
      n_vec++;
      n_err++;
      $error("FAIL access_timeout: observed stall stuck after %0d cycles expected release", stalls);
    end
    @(posedge clk);
    #1 idle_inputs();
  endtask

  task automatic ifetch(input logic [31:0] a, output int stalls);
    access(a, 1'b1, 4'h0, '0, '0, 1'b0, 4'h0, '0, stalls);
  endtask

  task automatic iwrite(input logic [31:0] a, input logic [31:0] d, output int stalls);
    access(a, 1'b0, 4'hF, d, '0, 1'b0, 4'h0, '0, stalls);
  endtask

  task automatic dwrite(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d, output int stalls);
    access('0, 1'b0, 4'h0, '0, a, 1'b0, we, d, stalls);
  endtask

  task automatic dread(input logic [31:0] a, output int stalls);
    access('0, 1'b0, 4'h0, '0, a, 1'b1, 4'h0, '0, stalls);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    do_reset();
    chk("rst_instruction", instruction, 32'h0);
    chk("rst_dout", dcache_dout, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_cnt_i", miss_count_i, 32'h0);
    chk("rst_cnt_d", miss_count_d, 32'h0);

    // Program load through the I port; first write of each line misses.
    iwrite(32'h0, 32'h2408_0005, st);
    chk("load_miss_stall", st, 32'd5);
    iwrite(32'h4, 32'h8C09_0004, st);
    chk("load_hit_stall", st, 32'd0);
    iwrite(32'h8, 32'h0109_5020, st);
    iwrite(32'hC, 32'hAC0A_0008, st);
    iwrite(32'h10, 32'h0800_0004, st);
    chk("load_line1_stall", st, 32'd5);

    // Reset keeps RAM; cold fetch misses again.
    do_reset();
    ifetch(32'h0, st);
    chk("cold_stall", st, 32'd5);
    chk("cold_instr", instruction, 32'h2408_0005);
    ifetch(32'h4, st);
    chk("hit4_stall", st, 32'd0);
    chk("hit4_instr", instruction, 32'h8C09_0004);
    ifetch(32'h8, st);
    chk("hit8_instr", instruction, 32'h0109_5020);
    ifetch(32'hC, st);
    chk("hitC_stall", st, 32'd0);
    chk("hitC_instr", instruction, 32'hAC0A_0008);
    ifetch(32'h10, st);
    chk("line_bound_stall", st, 32'd5);
    chk("line_bound_instr", instruction, 32'h0800_0004);

    // Byte-lane write.
    dwrite(32'h100, 4'hF, 32'h1122_3344, st);
    chk("d_cold_stall", st, 32'd5);
    dwrite(32'h100, 4'b0010, 32'hAABB_CCDD, st);
    chk("d_hit_stall", st, 32'd0);
    dread(32'h100, st);
    chk("byte_write", dcache_dout, 32'h1122_CC44);

    // Both ports write the same word: I wins; both ports miss so it is a dual stall.
    access(32'h40, 1'b0, 4'hF, 32'hDEAD_BEEF, 32'h40, 1'b0, 4'hF, 32'h0123_4567, st);
    chk("conflict_dual_stall", st, 32'd9);
    dread(32'h40, st);
    chk("conflict_readback", dcache_dout, 32'hDEAD_BEEF);

    // Disjoint lanes from both ports merge.
    access(32'h44, 1'b0, 4'b0011, 32'h0000_AAAA, 32'h44, 1'b0, 4'b1100, 32'hBBBB_0000, st);
    chk("merge_stall", st, 32'd0);
    dread(32'h44, st);
    chk("merge_readback", dcache_dout, 32'hBBBB_AAAA);

    // Same-port read-during-write returns old data.
    access('0, 1'b0, 4'h0, '0, 32'h44, 1'b1, 4'hF, 32'h1234_5678, st);
    chk("rdw_old", dcache_dout, 32'hBBBB_AAAA);
    dread(32'h44, st);
    chk("rdw_new", dcache_dout, 32'h1234_5678);

    // Cross-port read of a word written in the same cycle returns old data.
    dwrite(32'h48, 4'hF, 32'h5555_5555, st);
    access(32'h48, 1'b1, 4'h0, '0, 32'h48, 1'b0, 4'hF, 32'h6666_6666, st);
    chk("xport_old", instruction, 32'h5555_5555);
    dread(32'h48, st);
    chk("xport_new", dcache_dout, 32'h6666_6666);

    // Dual cold read miss.
    dwrite(32'h200, 4'hF, 32'hCAFE_F00D, st);
    do_reset();
    access(32'h0, 1'b1, 4'h0, '0, 32'h200, 1'b1, 4'h0, '0, st);
    chk("dual_stall", st, 32'd9);
    chk("dual_instr", instruction, 32'h2408_0005);
    chk("dual_dout", dcache_dout, 32'hCAFE_F00D);
    chk("dual_cnt_i", miss_count_i, EXP_DUAL_CNT);
    chk("dual_cnt_d", miss_count_d, EXP_DUAL_CNT);

    // Reset in the middle of an I fill (cnt=2).
    icache_addr = 32'h10;
    icache_re   = 1'b1;
    #1;
    chk("midfill_miss_stall", {31'b0, stall}, 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("midfill_in_fill", {31'b0, stall}, 32'd1);
    rst = 1'b1;
    icache_re = 1'b0;
    @(posedge clk);
    #1;
    chk("midfill_rst_stall", {31'b0, stall}, 32'd0);
    chk("midfill_rst_instr", instruction, 32'h0);
    chk("midfill_rst_dout", dcache_dout, 32'h0);
    chk("midfill_rst_cnt_i", miss_count_i, 32'h0);
    rst = 1'b0;
    ifetch(32'h0, st);
    chk("refetch_stall", st, 32'd5);
    chk("refetch_instr", instruction, 32'h2408_0005);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
